// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM stage: widths, FSM encoding and
// the default bus timeout.
package mem_pkg;
  localparam int DATA_W                 = 32;
  localparam int ADDR_W                 = 32;
  localparam int REG_ADDR_W             = 5;
  localparam int CNT_W                  = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without an ack; hit flags the cycle that reaches the limit.
module mem_timeout_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // count holds the number of completed waiting cycles, so the current
  // waiting cycle is the limit-th one when count == limit-1.
  assign hit = enable && (count >= (limit - CNT_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the data-memory bus, stalls the upstream pipe
// while an access is outstanding and registers the MEM/WB outputs.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [ADDR_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] write_reg_addr,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [DATA_W-1:0]     wb_read_data,
  output logic [ADDR_W-1:0]     wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_write_reg_addr,
  output logic                  align_err,
  output logic                  bus_err,
  output mem_state_t            fsm_state
);

  // Bus handshake: dmem_req rises with a stable addr/we/wdata and holds them
  // until the cycle dmem_ack is sampled high (or the timeout fires); ack is
  // a single-cycle response and is ignored whenever no request is pending.

  mem_state_t state;
  logic       access_valid;
  logic       misaligned;
  logic       go_busy;
  logic       cnt_enable;
  logic       timeout_hit;

  assign access_valid = (state == IDLE) && (mem_read || mem_write);
  assign misaligned   = (alu_result[1:0] != 2'b00);
  assign go_busy      = access_valid && !misaligned;
  assign cnt_enable   = (state == BUSY) && !dmem_ack;
  assign fsm_state    = state;

  mem_timeout_counter u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (go_busy),
    .enable (cnt_enable),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .hit    (timeout_hit)
  );

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (state == IDLE) stall = go_busy;
      else               stall = !dmem_ack && !timeout_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      wb_reg_write      <= 1'b0;
      wb_mem_to_reg     <= 1'b0;
      wb_read_data      <= '0;
      wb_alu_result     <= '0;
      wb_write_reg_addr <= '0;
      align_err         <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (go_busy) begin
            dmem_req      <= 1'b1;
            dmem_we       <= mem_write;
            dmem_addr     <= alu_result;
            dmem_wdata    <= write_data;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            state         <= BUSY;
          end else begin
            // A misaligned access becomes a non-writing op that flags align_err.
            wb_reg_write      <= reg_write && !access_valid;
            wb_mem_to_reg     <= mem_to_reg;
            wb_read_data      <= '0;
            wb_alu_result     <= alu_result;
            wb_write_reg_addr <= write_reg_addr;
            align_err         <= access_valid;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req          <= 1'b0;
            wb_reg_write      <= reg_write;
            wb_mem_to_reg     <= mem_to_reg;
            wb_read_data      <= dmem_we ? '0 : dmem_rdata;
            wb_alu_result     <= alu_result;
            wb_write_reg_addr <= write_reg_addr;
            state             <= IDLE;
          end else if (timeout_hit) begin
            dmem_req      <= 1'b0;
            bus_err       <= 1'b1;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            state         <= IDLE;
          end else begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short bus timeout of 4 cycles.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic [31:0] alu_result, write_data, dmem_rdata;
  logic [4:0]  write_reg_addr;
  logic        dmem_ack;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg_addr;
  logic        align_err, bus_err;
  mem_state_t  fsm_state;

  int total = 0;
  int bad   = 0;
  int stalls;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .reg_write         (reg_write),
    .mem_to_reg        (mem_to_reg),
    .alu_result        (alu_result),
    .write_data        (write_data),
    .write_reg_addr    (write_reg_addr),
    .stall             (stall),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .wb_reg_write      (wb_reg_write),
    .wb_mem_to_reg     (wb_mem_to_reg),
    .wb_read_data      (wb_read_data),
    .wb_alu_result     (wb_alu_result),
    .wb_write_reg_addr (wb_write_reg_addr),
    .align_err         (align_err),
    .bus_err           (bus_err),
    .fsm_state         (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd_addr);
    mem_read       = rd;
    mem_write      = wr;
    reg_write      = rw;
    mem_to_reg     = m2r;
    alu_result     = addr;
    write_data     = wdata;
    write_reg_addr = rd_addr;
  endtask

  // Runs one aligned access already driven on the inputs; ack is given in
  // cycle ack_cycle (cycle 0 is the IDLE cycle). Bus fields are checked in
  // every BUSY cycle; returns how many cycles stall was seen high.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_cycle, input logic [31:0] rdata, output int n_stall);
    n_stall = 0;
    for (int c = 0; c < 12; c++) begin
      dmem_ack   = (c == ack_cycle);
      dmem_rdata = rdata;
      #1;
      if (c > 0) begin
        chk("busy_req", 32'(dmem_req), 32'd1);
        chk("busy_addr", dmem_addr, addr);
        chk("busy_we", 32'(dmem_we), 32'(we));
        if (we) chk("busy_wdata", dmem_wdata, wdata);
        chk("busy_bubble", 32'(wb_reg_write), 32'd0);
      end
      if (stall) n_stall++;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (c > 0 && fsm_state == IDLE) break;
      if (c == 11) chk("access_bound", 32'(fsm_state), 32'(IDLE));
    end
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;

    // Non-memory op passes straight through with one cycle of latency
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    step();
    chk("alu_wb_res", wb_alu_result, 32'h10);
    chk("alu_wb_addr", 32'(wb_write_reg_addr), 32'd5);
    chk("alu_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("alu_wb_rd", wb_read_data, 32'h0);

    // Load, ack after 3 waiting BUSY cycles; ack coincides with the timeout limit
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7);
    access(1'b0, 32'h100, 32'h0, 4, 32'hDEAD_BEEF, stalls);
    chk("ld_stalls", 32'(stalls), 32'd4);
    chk("ld_rdata", wb_read_data, 32'hDEAD_BEEF);
    chk("ld_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("ld_wb_m2r", 32'(wb_mem_to_reg), 32'd1);
    chk("ld_wb_addr", 32'(wb_write_reg_addr), 32'd7);
    chk("ld_req_low", 32'(dmem_req), 32'd0);
    chk("ld_no_buserr", 32'(bus_err), 32'd0);

    // Store with immediate ack
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h1234_5678, 5'd0);
    access(1'b1, 32'h204, 32'h1234_5678, 1, 32'hAAAA_5555, stalls);
    chk("st_stalls", 32'(stalls), 32'd1);
    chk("st_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("st_rdata", wb_read_data, 32'h0);

    // Read and write both high: the write wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 5'd0);
    access(1'b1, 32'h300, 32'hCAFE_F00D, 1, 32'h1111_2222, stalls);
    chk("rw_rdata", wb_read_data, 32'h0);

    // Misaligned load
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd3);
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    step();
    chk("mis_align", 32'(align_err), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_wb_rw", 32'(wb_reg_write), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("mis_pulse", 32'(align_err), 32'd0);

    // Stray ack in IDLE
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd9);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5A5A_5A5A;
    step();
    dmem_ack = 1'b0;
    chk("ack_idle_state", 32'(fsm_state), 32'(IDLE));
    chk("ack_idle_req", 32'(dmem_req), 32'd0);
    chk("ack_idle_rd", wb_read_data, 32'h0);
    chk("ack_idle_res", wb_alu_result, 32'h44);

    // Timeout: no ack at all
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd4);
    access(1'b0, 32'h400, 32'h0, 99, 32'h0, stalls);
    chk("to_stalls", 32'(stalls), 32'd4);
    chk("to_buserr", 32'(bus_err), 32'd1);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("to_stall", 32'(stall), 32'd0);
    step();
    chk("to_pulse", 32'(bus_err), 32'd0);

    // Reset in the middle of BUSY
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0, 5'd6);
    step();
    chk("mid_req_hi", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_req_lo", 32'(dmem_req), 32'd0);
    chk("mid_state", 32'(fsm_state), 32'(IDLE));
    chk("mid_stall", 32'(stall), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0088, 32'h0, 5'd2);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_res", wb_alu_result, 32'h88);
    chk("post_rst_rw", 32'(wb_reg_write), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
